// File: rtl/cpu_pkg.sv
// Shared CPU types: FSM states, PC/writeback selects, opcodes and the
// main decoder table used by both the decoder and multicycle_ctrl.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef struct packed {
    logic reg_write;
    logic alu_src;
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic branch;
    logic jump;
  } dec_t;

  // Controls held from DECODE until the instruction retires
  typedef struct packed {
    logic alu_src;
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic branch;
    logic jump;
  } ctrl_t;

  function automatic dec_t decode(input logic [6:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_LOAD: begin
        d.reg_write  = 1'b1;
        d.alu_src    = 1'b1;
        d.mem_read   = 1'b1;
        d.mem_to_reg = 1'b1;
      end
      OP_OPIMM, OP_AUIPC, OP_LUI: begin
        d.reg_write = 1'b1;
        d.alu_src   = 1'b1;
      end
      OP_STORE: begin
        d.alu_src   = 1'b1;
        d.mem_write = 1'b1;
      end
      OP_OP:     d.reg_write = 1'b1;
      OP_BRANCH: d.branch    = 1'b1;
      OP_JALR: begin
        d.reg_write = 1'b1;
        d.alu_src   = 1'b1;
        d.jump      = 1'b1;
      end
      OP_JAL: begin
        d.reg_write = 1'b1;
        d.jump      = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle RV control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP.
// Define MULTICYCLE_INSTRET_EN to add the 32-bit instret counter port.
module multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        reg_write,
  input  logic        alu_src,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic        mem_to_reg,
  input  logic        branch,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_b_imm,
  output logic [2:0]  state_o,
`ifdef MULTICYCLE_INSTRET_EN
  output logic [31:0] instret,
`endif
  output logic        illegal_o
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   illegal_q;
  logic   dec_zero;
  logic   unused_ok;

  assign dec_zero = ~|{reg_write, alu_src, mem_write,
                       mem_read, mem_to_reg, branch, jump};

  // opcode is already folded into the decoder inputs
  assign unused_ok = ctrl_q.mem_to_reg ^ (^opcode);

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:
        state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE:
        state_d = dec_zero ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        if (ctrl_q.branch)
          state_d = ST_FETCH;
        else if (ctrl_q.mem_read || ctrl_q.mem_write)
          state_d = ST_MEM;
        else
          state_d = ST_WB;
      end
      ST_MEM: begin
        if (!mem_ready)
          state_d = ST_MEM;
        else if (ctrl_q.mem_write)
          state_d = ST_FETCH;
        else
          state_d = ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        ctrl_q.alu_src    <= alu_src;
        ctrl_q.mem_write  <= mem_write;
        ctrl_q.mem_read   <= mem_read;
        ctrl_q.mem_to_reg <= mem_to_reg;
        ctrl_q.branch     <= branch;
        ctrl_q.jump       <= jump;
        if (dec_zero)
          illegal_q <= 1'b1;
      end
    end
  end

  // Reset gates every output so nothing escapes in the reset cycle
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_b_imm = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_we    = mem_ready;
        end
        ST_DECODE: alu_b_imm = alu_src;
        ST_EXEC: begin
          alu_b_imm = ctrl_q.alu_src;
          if (ctrl_q.branch) begin
            pc_we  = 1'b1;
            pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
          end
        end
        ST_MEM: begin
          alu_b_imm = ctrl_q.alu_src;
          dmem_req  = 1'b1;
          dmem_we   = ctrl_q.mem_write;
          pc_we     = mem_ready & ctrl_q.mem_write;
        end
        ST_WB: begin
          alu_b_imm = ctrl_q.alu_src;
          rf_we     = 1'b1;
          pc_we     = 1'b1;
          unique case (1'b1)
            ctrl_q.mem_read: begin
              wb_sel = WB_MEM;
              pc_sel = PC_PLUS4;
            end
            ctrl_q.jump && !ctrl_q.alu_src: begin
              wb_sel = WB_PC4;
              pc_sel = PC_IMM;
            end
            ctrl_q.jump && ctrl_q.alu_src: begin
              wb_sel = WB_PC4;
              pc_sel = PC_ALU;
            end
            default: begin
              wb_sel = WB_ALU;
              pc_sel = PC_PLUS4;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign state_o   = rst ? 3'd0 : state_q;
  assign illegal_o = illegal_q & ~rst;

`ifdef MULTICYCLE_INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst)
      instret_q <= '0;
    else if (pc_we)
      instret_q <= instret_q + 32'd1;
  end

  assign instret = rst ? 32'd0 : instret_q;
`endif

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  7  instruction opcode field, valid from DECODE onward
- reg_write, alu_src, mem_write, mem_read, mem_to_reg, branch, jump  in  1 each  decoded control from the instruction decoder
- branch_taken  in  1  ALU compare result, sampled in EXECUTE
- mem_ready  in  1  memory handshake; may be high in the same cycle as the request
- imem_req  out  1  instruction fetch request
- ir_we  out  1  instruction register load
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write qualifier
- rf_we  out  1  register file write enable
- wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4
- pc_we  out  1  PC update enable
- pc_sel  out  2  next PC: 0 = PC+4, 1 = PC+imm, 2 = ALU result
- alu_b_imm  out  1  registered copy of alu_src, held from DECODE through WRITEBACK
- state_o  out  3  current state encoding
- illegal_o  out  1  sticky illegal-instruction flag

Function
REQ-003 The FSM SHALL have the states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4 and TRAP=5; encodings 6 and 7 SHALL return to FETCH on the next clock.
REQ-004 In FETCH the block SHALL assert imem_req. When mem_ready is high in that cycle, it SHALL pulse ir_we and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-005 DECODE SHALL last one cycle and latch alu_src, mem_write, mem_read, mem_to_reg, branch and jump into internal registers.
REQ-006 In DECODE, if all seven decoder inputs are 0, the block SHALL go to TRAP; otherwise it SHALL go to EXECUTE.
REQ-007 EXECUTE SHALL last one cycle and branch on the latched controls:
- branch set: pc_we=1 and pc_sel = branch_taken ? 1 : 0, then FETCH.
- mem_read or mem_write set: go to MEM.
- jump set, or any other instruction: go to WRITEBACK.
REQ-008 In MEM the block SHALL assert dmem_req, with dmem_we equal to the latched mem_write. It SHALL wait for mem_ready. On mem_ready:
- store: pc_we=1, pc_sel=0, then FETCH.
- load: go to WRITEBACK.
REQ-009 WRITEBACK SHALL last one cycle and assert rf_we=1 and pc_we=1, with wb_sel and pc_sel set as follows:
- load: wb_sel=1, pc_sel=0.
- jump without alu_src (JAL): wb_sel=2, pc_sel=1.
- jump with alu_src (JALR): wb_sel=2, pc_sel=2.
- otherwise: wb_sel=0, pc_sel=0.
REQ-010 TRAP SHALL hold all request and enable outputs at 0 and keep illegal_o=1 until reset.
REQ-011 All outputs other than state_o and illegal_o SHALL be combinational decodes of the state and latched controls, and SHALL be 0 in any state or condition not listed above.
REQ-012 mem_ready SHALL be ignored whenever imem_req and dmem_req are both 0.
REQ-013 With zero-wait memory, latencies SHALL be:
- R/I-type, JAL, JALR: 4 cycles.
- branch: 3 cycles.
- store: 4 cycles.
- load: 5 cycles.
- Each wait cycle (mem_ready low) SHALL add one cycle.

Reset
REQ-014 While rst is high on a clock edge, the state SHALL become FETCH, illegal_o and all latched controls SHALL become 0, and all outputs SHALL be forced to 0 in the cycle rst is asserted.
REQ-015 Reset asserted in the middle of a MEM wait SHALL drop dmem_req in the same cycle, with no write pulse generated.

Configuration
REQ-016 When MULTICYCLE_INSTRET_EN is defined, the block SHALL add the output instret (out, 32 bits).
- instret SHALL reset to 0 and increment by 1 on every cycle in which pc_we=1.
- It SHALL wrap from 0xFFFFFFFF to 0.
REQ-017 When MULTICYCLE_INSTRET_EN is not defined, neither the instret port nor its counter logic SHALL exist.

Structure
REQ-018 The state encodings, the pc_sel/wb_sel encodings and the opcode constants SHALL be defined in the shared package cpu_pkg, and the decoder SHALL use the same package.
REQ-019 The block SHALL be a single module with no sub-modules.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- R-type (0x33, reg_write=1) with mem_ready tied high: states 0,1,2,4,0; rf_we=1 and wb_sel=0 in cycle 4; pc_we=1 and pc_sel=0 in cycle 4.
- Load (0x03) with mem_ready low for 2 MEM cycles: dmem_req high for 3 cycles with dmem_we=0; WRITEBACK has wb_sel=1; total 7 cycles.
- BEQ (0x63) with branch_taken=1: pc_sel=1 and pc_we=1 in EXECUTE; no rf_we; back in FETCH after 3 cycles. Repeating with branch_taken=0 gives pc_sel=0.
- JALR (0x67, alu_src=1, jump=1): WRITEBACK has wb_sel=2 and pc_sel=2. JAL (0x6F) gives pc_sel=1.
- Opcode 0x7F with all decoder inputs 0: TRAP entered after DECODE; illegal_o=1 held for 100 cycles with no requests; rst pulse returns the block to FETCH with illegal_o=0.
- With MULTICYCLE_INSTRET_EN defined, preload instret to 0xFFFFFFFE via forced state, then run 3 R-type instructions: instret reads 1.
